// File: rtl/mp_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mp_add_seq_if
// Description : Handshake bundle for the slice-serial multi-precision adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface mp_add_seq_if #(
  parameter int W = 8
);
  logic         start;
  logic         cin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_slice;
  logic [W-1:0] b_slice;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_slice;
  logic         out_last;
  logic         cout;
  logic         busy;
  logic         done;

  modport master (
    output start, cin, in_valid, a_slice, b_slice, out_ready,
    input  in_ready, out_valid, sum_slice, out_last, cout, busy, done
  );

  modport slave (
    input  start, cin, in_valid, a_slice, b_slice, out_ready,
    output in_ready, out_valid, sum_slice, out_last, cout, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : mp_add_seq
// Description : Adds two N*W-bit operands one W-bit slice per transfer,
//               LS slice first, rippling the carry between slices.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_add_seq #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mp_add_seq_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] c_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;
  logic          r_out_last;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_done;

  logic          w_start;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_consume;
  logic          w_last_in;
  logic [W:0]    w_add;

  // Single-entry output register: refill allowed in the same cycle it drains.
  assign w_start    = (r_state == S_IDLE) && bus.start;
  assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_consume  = r_out_valid && bus.out_ready;
  assign w_last_in  = (r_cnt == c_LAST);
  assign w_add      = {1'b0, bus.a_slice} + {1'b0, bus.b_slice} + {{W{1'b0}}, r_carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept && w_last_in) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_consume) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_carry <= bus.cin;
        r_cnt   <= '0;
        r_cout  <= 1'b0;
      end
      if (w_accept) begin
        r_sum       <= w_add[W-1:0];
        r_carry     <= w_add[W];
        r_out_last  <= w_last_in;
        r_out_valid <= 1'b1;
        r_cnt       <= w_last_in ? '0 : r_cnt + CW'(1);
        if (w_last_in) begin
          r_cout <= w_add[W];
        end
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      // In FLUSH the only slice left in the register is the last one.
      if (w_consume && (r_state == S_FLUSH)) begin
        r_done <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum_slice = r_sum;
  assign bus.out_last  = r_out_last;
  assign bus.cout      = r_cout;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_add_seq
// Description : Directed and randomised self-checking bench for mp_add_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_add_seq;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TW = W * N;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mp_add_seq_if #(.W(W)) bus ();

  mp_add_seq #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: out_ready always high, 1: out_ready toggles, 2: random valid/ready
  task automatic do_add(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic ci,
                        input int mode, input bit poke,
                        input logic [TW-1:0] exp_sum, input logic exp_cout);
    logic [TW-1:0] got;
    logic [W-1:0]  held;
    int            ii;
    int            io;
    int            cyc;
    bit            stall;
    got = '0; held = '0; ii = 0; io = 0; cyc = 0; stall = 0;
    bus.start = 1'b1; bus.cin = ci; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    step();
    bus.start = 1'b0; bus.cin = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    while (io < N && cyc < 400) begin
      bus.start = poke && (cyc == 1);
      bus.cin   = poke && (cyc == 1);
      if (ii < N) begin
        bus.a_slice  = a[ii*W +: W];
        bus.b_slice  = b[ii*W +: W];
        bus.in_valid = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (mode == 0)      bus.out_ready = 1'b1;
      else if (mode == 1) bus.out_ready = (cyc % 2 == 0);
      else                bus.out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_hold", bus.sum_slice, held);
      end
      stall = bus.out_valid && !bus.out_ready;
      held  = bus.sum_slice;
      if (bus.out_valid && bus.out_ready) begin
        got[io*W +: W] = bus.sum_slice;
        chk("out_last", bus.out_last, (io == N - 1));
        if (io == N - 1) chk("cout_at_last", bus.cout, exp_cout);
        io++;
      end
      if (bus.in_valid && bus.in_ready) ii++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.start = 1'b0; bus.cin = 1'b0;
    chk("slices_consumed", io, N);
    chk("sum", got, exp_sum);
    chk("done_pulse", bus.done, 1);
    chk("idle_after_done", bus.busy, 0);
    step();
    chk("done_one_cycle", bus.done, 0);
    chk("cout_stable", bus.cout, exp_cout);
  endtask

  initial begin
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic          rc;
    logic [TW:0]   model;
    rst = 1'b1;
    bus.start = 1'b0; bus.cin = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a_slice = '0; bus.b_slice = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_sum", bus.sum_slice, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_done", bus.done, 0);

    // All-ones plus one: carry ripples through every slice.
    do_add(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, 32'h00000000, 1'b1);
    // Carry-in alone.
    do_add(32'h00000000, 32'h00000000, 1'b1, 0, 1'b0, 32'h00000001, 1'b0);
    // Back-pressure every other cycle.
    do_add(32'h12345678, 32'h0FEDCBA9, 1'b0, 1, 1'b0, 32'h22222221, 1'b0);
    // start with cin=1 while running must be ignored.
    do_add(32'h000000FF, 32'h00000001, 1'b0, 0, 1'b1, 32'h00000100, 1'b0);

    // Reset mid-operation after two slices have been accepted.
    bus.start = 1'b1; bus.cin = 1'b1;
    step();
    bus.start = 1'b0; bus.cin = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.a_slice = 8'hFF; bus.b_slice = 8'h01;
    step();
    step();
    rst = 1'b1; bus.start = 1'b1;
    step();
    rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_cout", bus.cout, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    do_add(32'h80000000, 32'h80000000, 1'b1, 0, 1'b0, 32'h00000001, 1'b1);

    for (int k = 0; k < 200; k++) begin
      ra    = $urandom;
      rb    = $urandom;
      rc    = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + {{TW{1'b0}}, rc};
      do_add(ra, rb, rc, 2, 1'b0, model[TW-1:0], model[TW]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
